// File: rtl/apb_perf_pkg.sv
// Shared types, violation bit indices and the saturating-add helper for the APB performance monitor.
package apb_perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int PERR_MULTI_SEL   = 0;
  localparam int PERR_EN_NO_SETUP = 1;
  localparam int PERR_UNSTABLE    = 2;
  localparam int PERR_SEL_DROP    = 3;

  // Adds b to a and clamps at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    sat_add = (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/apb_perf_chan_cnt.sv
// Per-channel statistics: saturating read/write/error counts, latency sum and latency maximum.
module apb_perf_chan_cnt
  import apb_perf_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int LAT_WIDTH = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 done,
  input  logic                 is_wr,
  input  logic                 err,
  input  logic [LAT_WIDTH-1:0] latency,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] wr_cnt,
  output logic [CNT_WIDTH-1:0] rd_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] lat_sum,
  output logic [LAT_WIDTH-1:0] lat_max
);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
      lat_sum <= '0;
      lat_max <= '0;
    end else if (clear) begin
      // clear outranks a completion landing in the same cycle
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
      lat_sum <= '0;
      lat_max <= '0;
    end else if (done) begin
      if (is_wr) wr_cnt <= CNT_WIDTH'(sat_add(64'(wr_cnt), 64'd1, CNT_WIDTH));
      else       rd_cnt <= CNT_WIDTH'(sat_add(64'(rd_cnt), 64'd1, CNT_WIDTH));
      if (err)   err_cnt <= CNT_WIDTH'(sat_add(64'(err_cnt), 64'd1, CNT_WIDTH));
      lat_sum <= CNT_WIDTH'(sat_add(64'(lat_sum), 64'(latency), CNT_WIDTH));
      if (latency > lat_max) lat_max <= latency;
    end
  end

endmodule

// File: rtl/apb_perf_monitor.sv
// Passive APB3/APB4 performance monitor: phase FSM, latency counter, protocol checks, per-slave stats.
module apb_perf_monitor
  import apb_perf_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 32,
  parameter int    DATA_WIDTH   = 32,
  parameter int    NUM_SEL      = 4,
  parameter int    CNT_WIDTH    = 32,
  parameter int    LAT_WIDTH    = 16,
  parameter string log_filename = "apb_perf"
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_SEL-1:0]             PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH-1:0]          PRDATA,
  input  logic                           PREADY,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic                           PSLVERR,
  input  logic                           clear_i,
  output logic [63:0]                    cycle_cnt_o,
  output logic [NUM_SEL*CNT_WIDTH-1:0]   wr_cnt_o,
  output logic [NUM_SEL*CNT_WIDTH-1:0]   rd_cnt_o,
  output logic [NUM_SEL*CNT_WIDTH-1:0]   err_cnt_o,
  output logic [NUM_SEL*CNT_WIDTH-1:0]   lat_sum_o,
  output logic [NUM_SEL*LAT_WIDTH-1:0]   lat_max_o,
  output logic [3:0]                     proto_err_o
);

  localparam int SEL_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

  apb_state_e              state_q, state_d;
  logic [LAT_WIDTH-1:0]    lat_q, lat_d, lat_inc;
  logic [NUM_SEL-1:0]      sel_q;
  logic [SEL_W-1:0]        idx_q, low_idx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic [63:0]             cycle_q;
  logic [3:0]              perr_q, perr_set;
  logic                    capture, access, done, unstable;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_SEL - 1; i >= 0; i--)
      if (PSEL[i]) low_idx = SEL_W'(i);
  end

  assign lat_inc  = (lat_q == {LAT_WIDTH{1'b1}}) ? lat_q : lat_q + 1'b1;
  assign unstable = (PADDR != addr_q) || (PWRITE != pwrite_q) ||
                    (PWDATA != wdata_q) || (PSTRB != strb_q);

  // state_q is the phase of the previous cycle; the current cycle is classified from it and the bus
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    capture  = 1'b0;
    access   = 1'b0;
    done     = 1'b0;
    perr_set = '0;
    perr_set[PERR_MULTI_SEL] = (PSEL & (PSEL - NUM_SEL'(1))) != '0;
    case (state_q)
      IDLE: begin
        if (PENABLE) begin
          perr_set[PERR_EN_NO_SETUP] = 1'b1;
        end else if (|PSEL) begin
          state_d = SETUP;
          lat_d   = LAT_WIDTH'(1);
          capture = 1'b1;
        end
      end
      SETUP: begin
        if (!PENABLE) begin
          state_d = IDLE;
        end else if (PSEL != sel_q) begin
          perr_set[PERR_SEL_DROP] = 1'b1;
          state_d = IDLE;
        end else begin
          access = 1'b1;
        end
      end
      ACCESS: begin
        if (PSEL != sel_q) begin
          perr_set[PERR_SEL_DROP] = 1'b1;
          state_d = IDLE;
        end else begin
          access = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      perr_set[PERR_UNSTABLE] = unstable;
      if (PREADY) begin
        done    = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = ACCESS;
        lat_d   = lat_inc;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      lat_q   <= '0;
      cycle_q <= '0;
      perr_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cycle_q <= cycle_q + 64'd1;
      perr_q  <= clear_i ? 4'd0 : (perr_q | perr_set);
    end
  end

  // Setup-phase snapshot used for the stability checks and completion attribution
  always_ff @(posedge PCLK) begin
    if (capture) begin
      sel_q    <= PSEL;
      idx_q    <= low_idx;
      addr_q   <= PADDR;
      pwrite_q <= PWRITE;
      wdata_q  <= PWDATA;
      strb_q   <= PSTRB;
    end
  end

  for (genvar k = 0; k < NUM_SEL; k++) begin : g_chan
    apb_perf_chan_cnt #(
      .CNT_WIDTH (CNT_WIDTH),
      .LAT_WIDTH (LAT_WIDTH)
    ) u_cnt (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .done    (done && (idx_q == SEL_W'(k))),
      .is_wr   (pwrite_q),
      .err     (PSLVERR),
      .latency (lat_inc),
      .clear   (clear_i),
      .wr_cnt  (wr_cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .rd_cnt  (rd_cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .err_cnt (err_cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .lat_sum (lat_sum_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .lat_max (lat_max_o[k*LAT_WIDTH +: LAT_WIDTH])
    );
  end

  assign cycle_cnt_o = cycle_q;
  assign proto_err_o = perr_q;

  localparam string unused_log_filename = log_filename;
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;

endmodule
